// File: rtl/adder_scheduler.sv
// adder_scheduler: round-robin arbiter sharing one registered adder between
// NUM_REQ requesters. One operation is in flight at a time (IDLE -> CALC -> RESP).
//
// Ports:
//   clk, rst_n           clock (rising edge), async active-low reset
//   req_valid[NUM_REQ]   requester i offers an operand pair
//   req_ready[NUM_REQ]   combinational one-hot grant, IDLE cycle only
//   req_a, req_b         packed operands, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   rsp_valid/rsp_ready  response handshake
//   rsp_data             A+B, DATA_WIDTH+1 bits
//   rsp_id               index of the requester that produced rsp_data
//   op_count             completed responses, wrapping 16-bit counter
module adder_scheduler #(
    parameter int unsigned DATA_WIDTH = 4,
    parameter int unsigned NUM_REQ    = 4,
    localparam int unsigned ID_W      = $clog2(NUM_REQ)
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_REQ-1:0]              req_valid,
    output logic [NUM_REQ-1:0]              req_ready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_a,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_b,
    output logic                            rsp_valid,
    input  logic                            rsp_ready,
    output logic [DATA_WIDTH:0]             rsp_data,
    output logic [ID_W-1:0]                 rsp_id,
    output logic [15:0]                     op_count
);

    localparam int unsigned SUM_W = DATA_WIDTH + 1;
    localparam int unsigned CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                 state;
    state_t                 state_nxt;

    logic [ID_W-1:0]        ptr;
    logic [DATA_WIDTH-1:0]  op_a;
    logic [DATA_WIDTH-1:0]  op_b;
    logic [ID_W-1:0]        op_id;

    logic [DATA_WIDTH-1:0]  a_arr [NUM_REQ];
    logic [DATA_WIDTH-1:0]  b_arr [NUM_REQ];

    logic                   grant_valid;
    logic [ID_W-1:0]        grant_id;
    logic [ID_W-1:0]        scan_idx;

    logic                   accept;
    logic                   calc_en;
    logic                   rsp_done;

    // Unpack the operand buses so the winner can be selected by index
    for (genvar i = 0; i < int'(NUM_REQ); i++) begin : g_unpack
        assign a_arr[i] = req_a[i*DATA_WIDTH +: DATA_WIDTH];
        assign b_arr[i] = req_b[i*DATA_WIDTH +: DATA_WIDTH];
    end

    // Round-robin search: first valid requester at or after ptr, wrapping
    always_comb begin
        grant_valid = 1'b0;
        grant_id    = '0;
        scan_idx    = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            scan_idx = ID_W'((32'(ptr) + k) % NUM_REQ);
            if (!grant_valid && req_valid[scan_idx]) begin
                grant_valid = 1'b1;
                grant_id    = scan_idx;
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant_valid) state_nxt = CALC;
            CALC:    state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output / control decode; req_ready is the only combinational output
    always_comb begin
        req_ready = '0;
        accept    = 1'b0;
        calc_en   = 1'b0;
        rsp_done  = 1'b0;
        case (state)
            IDLE: begin
                if (grant_valid) begin
                    accept    = 1'b1;
                    req_ready = NUM_REQ'(1) << grant_id;
                end
            end
            CALC:    calc_en  = 1'b1;
            RESP:    rsp_done = rsp_ready;
            default: ;
        endcase
    end

    // Operand capture and pointer advance on a grant
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr   <= '0;
            op_a  <= '0;
            op_b  <= '0;
            op_id <= '0;
        end else if (accept) begin
            op_a  <= a_arr[grant_id];
            op_b  <= b_arr[grant_id];
            op_id <= grant_id;
            ptr   <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);
        end
    end

    // Adder stage and response registers; rsp_data/rsp_id hold while stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_id    <= '0;
            op_count  <= '0;
        end else begin
            if (calc_en) begin
                rsp_data  <= SUM_W'(op_a) + SUM_W'(op_b);
                rsp_id    <= op_id;
                rsp_valid <= 1'b1;
            end else if (rsp_done) begin
                rsp_valid <= 1'b0;
                op_count  <= op_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_adder_scheduler.sv
// tb_adder_scheduler: directed stimulus for adder_scheduler with a
// transaction-level model checked every cycle on the falling edge.
module tb_adder_scheduler;

    localparam int DW = 4;
    localparam int NR = 4;
    localparam int IW = $clog2(NR);

    logic               clk;
    logic               rst_n;
    logic [NR-1:0]      req_valid;
    logic [NR-1:0]      req_ready;
    logic [NR*DW-1:0]   req_a;
    logic [NR*DW-1:0]   req_b;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [DW:0]        rsp_data;
    logic [IW-1:0]      rsp_id;
    logic [15:0]        op_count;

    int n_chk  = 0;
    int n_fail = 0;

    adder_scheduler #(
        .DATA_WIDTH(DW),
        .NUM_REQ   (NR)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_a    (req_a),
        .req_b    (req_b),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_data (rsp_data),
        .rsp_id   (rsp_id),
        .op_count (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    // At most one operation outstanding; response is due two cycles after
    // its grant and stays due until accepted.
    int  cyc     = 0;
    bit  m_busy  = 0;
    int  m_ptr   = 0;
    int  m_gcyc  = 0;
    int  m_sum   = 0;
    int  m_id    = 0;
    int  m_count = 0;
    int  glog_id[$];
    int  glog_cyc[$];

    always @(negedge clk) begin
        int g;
        logic [NR-1:0] exp_ready;
        bit exp_rv;
        if (!rst_n) begin
            m_busy  = 0;
            m_ptr   = 0;
            m_count = 0;
            chk("rst_req_ready", 32'(req_ready), 0);
            chk("rst_rsp_valid", 32'(rsp_valid), 0);
            chk("rst_op_count",  32'(op_count), 0);
        end else begin
            g = -1;
            exp_ready = '0;
            if (!m_busy) begin
                for (int k = NR - 1; k >= 0; k--) begin
                    int j;
                    j = (m_ptr + k) % NR;
                    if (req_valid[j]) g = j;
                end
            end
            if (g >= 0) exp_ready[g] = 1'b1;
            exp_rv = m_busy && (cyc - m_gcyc >= 2);

            chk("req_ready", 32'(req_ready), 32'(exp_ready));
            chk("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
            if (exp_rv) begin
                chk("rsp_data", 32'(rsp_data), 32'(m_sum));
                chk("rsp_id",   32'(rsp_id),   32'(m_id));
            end
            chk("op_count", 32'(op_count), 32'(m_count & 16'hFFFF));

            for (int i = 0; i < NR; i++) begin
                if (req_ready[i]) begin
                    glog_id.push_back(i);
                    glog_cyc.push_back(cyc);
                end
            end

            if (g >= 0) begin
                m_busy = 1;
                m_gcyc = cyc;
                m_id   = g;
                m_sum  = int'(req_a[g*DW +: DW]) + int'(req_b[g*DW +: DW]);
                m_ptr  = (g + 1) % NR;
            end
            if (exp_rv && rsp_ready) begin
                m_busy  = 0;
                m_count = m_count + 1;
            end
        end
        cyc++;
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input int a, input int b);
        req_a[i*DW +: DW] = DW'(a);
        req_b[i*DW +: DW] = DW'(b);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_valid = '0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic do_op(input string name, input int i, input int a, input int b, input int exp_sum);
        bit seen;
        set_req(i, a, b);
        req_valid = NR'(1) << i;
        @(negedge clk);
        chk({name, "_grant"}, 32'(req_ready), 32'(NR'(1) << i));
        tick();
        req_valid = '0;
        seen = 0;
        for (int n = 0; n < 10 && !seen; n++) begin
            @(negedge clk);
            seen = rsp_valid;
        end
        chk({name, "_rsp_seen"}, 32'(seen), 1);
        chk({name, "_data"}, 32'(rsp_data), 32'(exp_sum));
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    // ---------------- directed tests ----------------
    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;
        tick();
        @(negedge clk);
        chk("reset_req_ready", 32'(req_ready), 0);
        chk("reset_rsp_valid", 32'(rsp_valid), 0);
        chk("reset_rsp_data",  32'(rsp_data), 0);
        chk("reset_op_count",  32'(op_count), 0);
        tick();
        rst_n = 1'b1;
        tick();

        // Single request: requester 2, 3+5
        set_req(2, 3, 5);
        req_valid = 4'b0100;
        @(negedge clk);
        chk("t1_ready", 32'(req_ready), 32'(4'b0100));
        tick();
        req_valid = '0;
        @(negedge clk);
        chk("t1_calc_no_rsp", 32'(rsp_valid), 0);
        chk("t1_calc_ready",  32'(req_ready), 0);
        tick();
        @(negedge clk);
        chk("t1_rsp_valid", 32'(rsp_valid), 1);
        chk("t1_rsp_data",  32'(rsp_data), 8);
        chk("t1_rsp_id",    32'(rsp_id), 2);
        tick();
        @(negedge clk);
        chk("t1_op_count", 32'(op_count), 1);
        tick();

        // Full contention after reset: 0,1,2,3,0 every 3 cycles
        do_reset();
        for (int i = 0; i < NR; i++) set_req(i, i*4 + 1, 15 - i*3);
        glog_id.delete();
        glog_cyc.delete();
        req_valid = 4'b1111;
        for (int n = 0; n < 40 && glog_id.size() < 5; n++) tick();
        req_valid = '0;
        chk("t2_grant_count", 32'(glog_id.size()), 5);
        if (glog_id.size() >= 5) begin
            chk("t2_order0", 32'(glog_id[0]), 0);
            chk("t2_order1", 32'(glog_id[1]), 1);
            chk("t2_order2", 32'(glog_id[2]), 2);
            chk("t2_order3", 32'(glog_id[3]), 3);
            chk("t2_order4", 32'(glog_id[4]), 0);
            for (int i = 1; i < 5; i++)
                chk("t2_interval", 32'(glog_cyc[i] - glog_cyc[i-1]), 3);
        end
        repeat (4) tick();

        // Width boundary
        do_op("t3_15p15", 0, 15, 15, 30);
        do_op("t3_15p1",  0, 15, 1, 16);
        do_op("t3_0p0",   0, 0, 0, 0);

        // Backpressure: 5 stalled RESP cycles with requester 3 pending
        do_reset();
        rsp_ready = 1'b0;
        set_req(1, 9, 4);
        req_valid = 4'b0010;
        tick();
        set_req(3, 2, 6);
        req_valid = 4'b1000;
        tick();
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            chk("t4_hold_valid", 32'(rsp_valid), 1);
            chk("t4_hold_data",  32'(rsp_data), 13);
            chk("t4_hold_id",    32'(rsp_id), 1);
            chk("t4_no_grant",   32'(req_ready), 0);
        end
        tick();
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("t4_resp_ready", 32'(req_ready), 0);
        tick();
        @(negedge clk);
        chk("t4_next_grant", 32'(req_ready), 32'(4'b1000));
        tick();
        req_valid = '0;
        repeat (3) tick();

        // Pointer skip: after requester 1, only 0 and 3 valid -> 3 then 0
        do_reset();
        set_req(1, 1, 1);
        req_valid = 4'b0010;
        tick();
        req_valid = '0;
        repeat (3) tick();
        glog_id.delete();
        glog_cyc.delete();
        set_req(0, 4, 4);
        set_req(3, 6, 1);
        req_valid = 4'b1001;
        for (int n = 0; n < 20 && glog_id.size() < 2; n++) tick();
        req_valid = '0;
        chk("t5_grant_count", 32'(glog_id.size()), 2);
        if (glog_id.size() >= 2) begin
            chk("t5_first",  32'(glog_id[0]), 3);
            chk("t5_second", 32'(glog_id[1]), 0);
        end
        repeat (4) tick();

        // Reset during CALC
        set_req(2, 5, 5);
        req_valid = 4'b0100;
        tick();
        req_valid = '0;
        rst_n = 1'b0;
        #1;
        chk("t6_async_op_count",  32'(op_count), 0);
        chk("t6_async_rsp_valid", 32'(rsp_valid), 0);
        chk("t6_async_rsp_data",  32'(rsp_data), 0);
        chk("t6_async_rsp_id",    32'(rsp_id), 0);
        chk("t6_async_req_ready", 32'(req_ready), 0);
        tick();
        tick();
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("t6_no_stale_rsp", 32'(rsp_valid), 0);
        end
        tick();
        set_req(1, 2, 3);
        set_req(3, 1, 1);
        req_valid = 4'b1010;
        @(negedge clk);
        chk("t6_ptr0_grant", 32'(req_ready), 32'(4'b0010));
        tick();
        req_valid = '0;
        repeat (4) tick();
        @(negedge clk);
        chk("t6_op_count", 32'(op_count), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/adder_scheduler.md
# adder_scheduler

Shares a single registered adder between `NUM_REQ` requesters. Each requester offers an operand pair under a valid/ready handshake. A round-robin arbiter grants one request at a time and sequences the operands through the adder stage. The result is returned on one response port, tagged with the winner's index, for the block that collects sums.

## Interface

Parameters:
- `DATA_WIDTH`, 4: operand width; the sum is `DATA_WIDTH+1` bits.
- `NUM_REQ`, 4: number of requesters, ≥2.
- `ID_W`, `$clog2(NUM_REQ)`: requester tag width. Derived; do not override.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `req_valid`  in  `NUM_REQ`: bit i set means requester i offers operands.
- `req_ready`  out  `NUM_REQ`: one-hot or zero; bit i set means requester i's operands are accepted this cycle.
- `req_a`  in  `NUM_REQ*DATA_WIDTH`: packed unsigned A operands; requester i uses slice `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `req_b`  in  `NUM_REQ*DATA_WIDTH`: packed unsigned B operands, same packing as `req_a`.
- `rsp_valid`  out  1: a result is presented.
- `rsp_ready`  in  1: the consumer accepts the result.
- `rsp_data`  out  `DATA_WIDTH+1`: unsigned A+B.
- `rsp_id`  out  `ID_W`: index of the requester that produced the result.
- `op_count`  out  16: number of completed responses, wrapping.

## Operation

- FSM states: IDLE, CALC, RESP. Reset state is IDLE.
- IDLE:
  - If any `req_valid` bit is set, grant g = the first set bit found searching from `ptr` upward, wrapping modulo `NUM_REQ`.
  - `req_ready[g]=1` combinationally, in this cycle only. The handshake completes this cycle.
  - Capture `req_a[g]`, `req_b[g]` and g into the operand registers; set `ptr <= (g+1) mod NUM_REQ`; go to CALC.
  - If no bit is set, stay in IDLE. `req_ready` is 0.
- CALC:
  - Registered add: `sum <= A + B`, computed at `DATA_WIDTH+1` bits, zero-extended, never truncated.
  - Go to RESP unconditionally.
- RESP:
  - `rsp_valid=1`. `rsp_data` and `rsp_id` are registered and held stable.
  - On `rsp_valid && rsp_ready`, increment `op_count` (wraps 0xFFFF→0) and go to IDLE.
  - Otherwise hold all values indefinitely.
- `req_ready` is 0 in every state except the IDLE grant cycle. No request is accepted while CALC or RESP is active.
- Requester i's `req_valid` may drop before it is granted. The arbiter uses only the current-cycle `req_valid`.
- `ptr` advances only on a grant. An unused slot does not consume the requester's turn.
- Reset values:
  - Outputs: `req_ready=0`, `rsp_valid=0`, `rsp_data=0`, `rsp_id=0`, `op_count=0`.
  - Internal: `ptr=0`, FSM=IDLE, operand registers 0.
- Reset mid-operation: an in-flight operation is discarded without a response. `rsp_valid` falls asynchronously with `rst_n`.

## Timing

- Request accepted at edge T, in the IDLE cycle with `req_ready[g]=1`.
- CALC occupies cycle T+1.
- `rsp_valid` rises after edge T+2.
- Minimum issue interval is 3 cycles when `rsp_ready` is held high: IDLE, CALC, RESP, then IDLE again.
- Results are delivered in grant order. Only one operation is in flight at a time.
- Every output except `req_ready` is a flop output. `req_ready` depends combinationally on `req_valid`, `ptr` and the state.

## Test plan

- Single request: requester 2 sends A=3, B=5, `rsp_ready=1` → `req_ready=4'b0100` for 1 cycle; response 2 cycles later with `rsp_data=8`, `rsp_id=2`; `op_count=1`.
- Full contention: all 4 `req_valid` held high with distinct operands after reset → grants in order 0,1,2,3,0; each response matches its requester's sum and id; issues are 3 cycles apart.
- Width boundary, `DATA_WIDTH=4`: A=15, B=15 → `rsp_data=5'd30`. A=15, B=1 → 16. A=0, B=0 → 0.
- Backpressure: `rsp_ready=0` for 5 cycles during RESP → `rsp_valid`, `rsp_data` and `rsp_id` stay stable; `req_ready` stays 0 despite pending requests; the next grant follows one cycle after `rsp_ready=1`.
- Pointer skip: after requester 1 is granted, only requesters 0 and 3 are valid → 3 is granted first, then 0.
- Reset during CALC: assert `rst_n=0` → all outputs return to reset values immediately; no response for the dropped operation; the next request after release is granted starting from `ptr=0`.
